// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared opcodes, shift-register mode encodings and sequencer
//               state encoding for the universal shift register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Mode select values on s share the opcode encoding.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic [1:0] op_to_mode(input logic [1:0] op);
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usr_cmd_slot.sv
`default_nettype none
// ============================================================================
// Module      : usr_cmd_slot
// Description : One-entry pending command buffer with push/pop ports.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_cmd_slot
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [1:0]       push_op,
    input  logic [CNT_W-1:0] push_cnt,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    output logic [1:0]       op,
    output logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [1:0]       op_q,    op_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Push only happens while empty and pop only while full, so a push
    // taking priority never discards a live entry.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            op_d    = push_op;
            cnt_d   = push_cnt;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign op    = op_q;
    assign cnt   = cnt_q;
    assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/usr_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : usr_shift_sequencer
// Description : Expands load/shift/hold commands into per-cycle controls for a
//               universal shift register and tracks a shadow of its contents.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       s,
    output logic             lsi,
    output logic             rsi,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       s_q,     s_d;
    logic             lsi_q,   lsi_d;
    logic             rsi_q,   rsi_d;
    logic [WIDTH-1:0] din_q,   din_d;
    logic             done_q,  done_d;
    logic             owed_q,  owed_d;
    logic [WIDTH-1:0] shadow_d;

    logic             slot_valid;
    logic [1:0]       slot_op;
    logic [CNT_W-1:0] slot_cnt;
    logic [WIDTH-1:0] slot_data;

    logic             accept;
    logic             last_drive;
    logic             can_start;
    logic             take_pend;
    logic             take_new;
    logic             push;
    logic [1:0]       nxt_op;
    logic [CNT_W-1:0] nxt_cnt;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_zero;

    assign cmd_ready  = !slot_valid;
    assign accept     = cmd_valid && cmd_ready;
    assign last_drive = (state_q == ST_RUN) && (cnt_q == '0);
    // A second done owed in FIN blocks starts for one cycle so pulses never merge.
    assign can_start  = (state_q == ST_IDLE)
                     || ((state_q == ST_FIN) && !owed_q)
                     || last_drive;
    assign take_pend  = can_start && slot_valid;
    assign take_new   = can_start && accept;
    assign push       = accept && !can_start;

    assign nxt_op   = take_pend ? slot_op   : cmd_op;
    assign nxt_cnt  = take_pend ? slot_cnt  : cmd_cnt;
    assign nxt_data = take_pend ? slot_data : cmd_data;
    assign nxt_zero = (nxt_op != OP_LOAD) && (nxt_cnt == '0);

    usr_cmd_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (take_pend),
        .push_op   (cmd_op),
        .push_cnt  (cmd_cnt),
        .push_data (cmd_data),
        .valid     (slot_valid),
        .op        (slot_op),
        .cnt       (slot_cnt),
        .data      (slot_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = MODE_HOLD;
        lsi_d   = 1'b0;
        rsi_d   = 1'b0;
        din_d   = din_q;
        done_d  = 1'b0;
        owed_d  = owed_q;

        case (state_q)
            ST_RUN: begin
                if (last_drive) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    s_d   = s_q;
                    lsi_d = lsi_q;
                    rsi_d = rsi_q;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIN: begin
                if (owed_q) begin
                    done_d = 1'b1;
                    owed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_pend || take_new) begin
            if (nxt_zero) begin
                state_d = ST_FIN;
                if (last_drive) begin
                    owed_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                state_d = ST_RUN;
                s_d     = op_to_mode(nxt_op);
                lsi_d   = (nxt_op == OP_SHL);
                rsi_d   = (nxt_op == OP_SHR);
                if (nxt_op == OP_LOAD) begin
                    cnt_d = '0;
                    din_d = nxt_data;
                end else begin
                    cnt_d = nxt_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Shadow follows the mode currently on s, shifting in zeros.
    always_comb begin
        shadow_d = shadow_q;
        case (s_q)
            MODE_SHR:  shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
            MODE_SHL:  shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
            MODE_LOAD: shadow_d = din_q;
            default:   shadow_d = shadow_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            s_q      <= MODE_HOLD;
            lsi_q    <= 1'b0;
            rsi_q    <= 1'b0;
            din_q    <= '0;
            done_q   <= 1'b0;
            owed_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            lsi_q    <= lsi_d;
            rsi_q    <= rsi_d;
            din_q    <= din_d;
            done_q   <= done_d;
            owed_q   <= owed_d;
            shadow_q <= shadow_d;
        end
    end

    assign s    = s_q;
    assign lsi  = lsi_q;
    assign rsi  = rsi_q;
    assign din  = din_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE) || slot_valid;

endmodule
`default_nettype wire

// File: tb/tb_usr_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_shift_sequencer
// Description : Directed self-checking bench for usr_shift_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       s;
    logic             lsi;
    logic             rsi;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shadow_q;

    int n_tests = 0;
    int n_fail  = 0;

    usr_shift_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .s         (s),
        .lsi       (lsi),
        .rsi       (rsi),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .shadow_q  (shadow_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [WIDTH-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
    endtask

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data);
        present(op, cnt, data);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_drive(input string tag, input logic [1:0] es, input logic el,
                               input logic er, input logic ed, input logic [WIDTH-1:0] esh);
        check({tag, "_s"},      32'(s),        32'(es));
        check({tag, "_lsi"},    32'(lsi),      32'(el));
        check({tag, "_rsi"},    32'(rsi),      32'(er));
        check({tag, "_done"},   32'(done),     32'(ed));
        check({tag, "_shadow"}, 32'(shadow_q), 32'(esh));
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = '0;
        step();
        step();

        check_drive("rst", 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("rst_din",   32'(din),       32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        reset = 1'b0;
        step();

        // LOAD 1011
        issue(2'b11, 3'd0, 4'b1011);
        check_drive("ld1", 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("ld1_din",  32'(din),  32'hB);
        check("ld1_busy", 32'(busy), 32'h1);
        step();
        check_drive("ld2", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1011);
        step();
        check("ld3_done", 32'(done), 32'h0);
        check("ld3_busy", 32'(busy), 32'h0);

        // SHR cnt=2
        issue(2'b01, 3'd2, 4'b0000);
        check_drive("shr1", 2'b01, 1'b0, 1'b1, 1'b0, 4'b1011);
        step();
        check_drive("shr2", 2'b01, 1'b0, 1'b1, 1'b0, 4'b0101);
        step();
        check_drive("shr3", 2'b00, 1'b0, 1'b0, 1'b1, 4'b0010);
        step();
        check("shr4_done", 32'(done), 32'h0);

        // HOLD 2, LOAD 0001 queued, SHL 3 bypassing at LOAD's drive cycle
        issue(2'b00, 3'd2, 4'b0000);
        check_drive("hq1", 2'b00, 1'b0, 1'b0, 1'b0, 4'b0010);
        check("hq1_ready", 32'(cmd_ready), 32'h1);
        issue(2'b11, 3'd0, 4'b0001);
        check("hq2_ready", 32'(cmd_ready), 32'h0);
        check("hq2_busy",  32'(busy),      32'h1);
        check("hq2_done",  32'(done),      32'h0);
        present(2'b10, 3'd3, 4'b0000);
        step();
        check_drive("lq1", 2'b11, 1'b0, 1'b0, 1'b1, 4'b0010);
        check("lq1_din",   32'(din),       32'h1);
        check("lq1_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        check_drive("shl1", 2'b10, 1'b1, 1'b0, 1'b1, 4'b0001);
        step();
        check_drive("shl2", 2'b10, 1'b1, 1'b0, 1'b0, 4'b0010);
        step();
        check_drive("shl3", 2'b10, 1'b1, 1'b0, 1'b0, 4'b0100);
        step();
        check_drive("shl4", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1000);
        step();
        check("shl5_done", 32'(done), 32'h0);

        // SHR cnt=0: no drive, immediate done
        issue(2'b01, 3'd0, 4'b0000);
        check_drive("z1", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1000);
        step();
        check_drive("z2", 2'b00, 1'b0, 1'b0, 1'b0, 4'b1000);
        check("z2_busy", 32'(busy), 32'h0);

        // Reset in 2nd cycle of SHL 5 with a pending command
        issue(2'b10, 3'd5, 4'b0000);
        check("ra1_s", 32'(s), 32'h2);
        issue(2'b00, 3'd3, 4'b0110);
        check("ra2_ready", 32'(cmd_ready), 32'h0);
        check("ra2_shadow", 32'(shadow_q), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_drive("ra3", 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("ra3_din",   32'(din),       32'h0);
        check("ra3_busy",  32'(busy),      32'h0);
        check("ra3_ready", 32'(cmd_ready), 32'h1);
        step();
        check("ra4_done", 32'(done), 32'h0);
        check("ra4_busy", 32'(busy), 32'h0);

        // HOLD 4 then LOAD 1111 queued
        issue(2'b00, 3'd4, 4'b0000);
        check_drive("h1", 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        issue(2'b11, 3'd0, 4'b1111);
        check("h2_busy", 32'(busy), 32'h1);
        check("h2_s",    32'(s),    32'h0);
        step();
        check("h3_busy", 32'(busy), 32'h1);
        check("h3_s",    32'(s),    32'h0);
        step();
        check("h4_busy", 32'(busy), 32'h1);
        check("h4_s",    32'(s),    32'h0);
        check("h4_done", 32'(done), 32'h0);
        step();
        check_drive("hl1", 2'b11, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("hl1_din", 32'(din), 32'hF);
        step();
        check_drive("hl2", 2'b00, 1'b0, 1'b0, 1'b1, 4'b1111);
        step();
        check("hl3_busy", 32'(busy), 32'h0);
        check("hl3_din",  32'(din),  32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usr_shift_sequencer.md
Name: usr_shift_sequencer

Overview:
- Command-driven control stage placed directly upstream of the 4-bit universal shift register.
- Accepts load, shift and hold commands over a valid/ready handshake, with a repeat count and load data.
- Expands each command into the per-cycle mode select, shift-in strobes and parallel data that drive the register.
- Keeps a shadow copy of the register contents so downstream logic and benches can check the register against it.

Parameters:
- WIDTH, 4, width of the shift register data path (din, shadow_q).
- CNT_W, 3, width of the repeat count; maximum count is 2^CNT_W-1 = 7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the sequencer can accept a command this cycle.
- cmd_op  input  2  command opcode: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
- cmd_cnt  input  CNT_W  number of shift/hold cycles; ignored for LOAD.
- cmd_data  input  WIDTH  load value; used for LOAD only.
- s  output  2  mode select to the shift register.
- lsi  output  1  left-shift qualifier; 1 only while executing SHL.
- rsi  output  1  right-shift qualifier; 1 only while executing SHR.
- din  output  WIDTH  parallel load data to the shift register.
- busy  output  1  a command is executing or one is pending.
- done  output  1  one-cycle pulse when a command completes.
- shadow_q  output  WIDTH  predicted contents of the shift register.

Behaviour:
- Reset:
  - s=00, lsi=0, rsi=0, din=0, done=0, busy=0, shadow_q=0, cmd_ready=1.
  - The FSM returns to IDLE and the pending slot is cleared.
  - Reset mid-command aborts the command; no done pulse is produced.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = !pend_valid, taken from registers only; it has no combinational path from cmd_valid.
  - The pending slot holds one command.
- Outputs:
  - s, lsi, rsi and din are registered.
  - Drive cycle 1 of a command accepted at edge T is the cycle after T.
- FSM states: IDLE, RUN, FIN.
  - IDLE, accept: load the op into the working registers and go to RUN. The command bypasses the pending slot.
  - IDLE, LOAD: exactly one drive cycle with s=11 and din=cmd_data.
  - IDLE, SHR/SHL/HOLD with cmd_cnt=N>0: N drive cycles with s=01, 10 or 00 respectively. A down-counter runs from N-1 to 0.
  - IDLE, cmd_cnt=0 for SHR/SHL/HOLD: no drive cycle; go directly to FIN, so done pulses the cycle after acceptance.
  - RUN, last drive cycle (counter==0 or LOAD): done pulses in the next cycle.
  - RUN, pending valid at the last drive cycle: the next cycle is also drive cycle 1 of the pending command (zero bubble), and done pulses concurrently with it.
  - RUN, no pending command at the last drive cycle: go to FIN; s returns to 00 and done pulses.
  - RUN, accept in the same cycle as the last drive with the pending slot empty: the new command goes straight to execution, as in the zero-bubble case.
  - FIN: done=1, then go to IDLE. If a command is accepted in FIN, go to RUN instead (no extra idle cycle).
- Outside drive cycles: s=00, lsi=rsi=0, din holds its last value.
- busy = (state!=IDLE) || pend_valid.
- Shadow model, updated at every edge from the registered s currently driven:
  - s=00: hold.
  - s=01: {0, q[WIDTH-1:1]}.
  - s=10: {q[WIDTH-2:0], 0}.
  - s=11: din.
  - Shifted-in bits are always 0.
  - The shadow matches the register only if both leave reset together.
- Count arithmetic is unsigned CNT_W bits; no wrap is possible because the counter stops at 0.

Decomposition:
- Shared package usr_pkg holds:
  - the opcode constants OP_HOLD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_LOAD=2'b11;
  - the mode encodings for s (identical values);
  - the FSM state encoding.
- Sub-module usr_cmd_slot: the one-entry pending buffer (valid, op, cnt, data) with push/pop ports.
- The shadow model stays inline.

Test Plan:
- Reset, then cmd LOAD data=1011 → next cycle s=11, din=1011; the cycle after that done=1, s=00, shadow_q=1011.
- LOAD 1011, then SHR cnt=2 → two cycles s=01, rsi=1; shadow_q goes 0101, then 0010; exactly one done pulse.
- SHL cnt=3 issued while LOAD 0001 is running (queued in the pending slot) → cmd_ready=0 while the slot is full; SHL drive starts with no gap after LOAD; shadow_q goes 0010, 0100, 1000; two done pulses in total.
- SHR cnt=0 → no s=01 cycle; done pulses the cycle after acceptance; shadow_q unchanged.
- Reset asserted in the 2nd cycle of SHL cnt=5 with a pending command → the next cycle shows all outputs 0, busy=0, cmd_ready=1 and no done pulse.
- HOLD cnt=4 followed by LOAD 1111 → four cycles with s=00 and busy=1, then s=11, din=1111, shadow_q=1111.
